// File: rtl/clkgen_pkg.sv
// -----------------------------------------------------------------------------
// clkgen_pkg
// Shared definitions for the clk_en_bank divider tree.
//   SRC_ROOT   : source selector value meaning "count every CLK_G cycle"
//   CNT_W_DEF  : default stage counter / ratio width
//   MAX_VEC_W  : widest packed parameter vector get_field can unpack
//   eff_div    : clamps a programmed ratio to the minimum usable divide of 2
//   get_field  : extracts field idx of width w from a packed vector
// -----------------------------------------------------------------------------
package clkgen_pkg;

  localparam logic [3:0] SRC_ROOT  = 4'hF;
  localparam int         CNT_W_DEF = 8;
  localparam int         MAX_VEC_W = 512;

  // Ratios of 0 and 1 cannot produce a level with both phases, so they behave
  // as a divide by 2.
  function automatic int unsigned eff_div(input int unsigned ratio);
    return (ratio < 32'd2) ? 32'd2 : ratio;
  endfunction

  // Fields are packed LSB first: field k occupies [w*k +: w].
  function automatic int unsigned get_field(input logic [MAX_VEC_W-1:0] vec,
                                            input int unsigned         idx,
                                            input int unsigned         w);
    return 32'((vec >> (idx * w)) &
               ((MAX_VEC_W'(1) << w) - MAX_VEC_W'(1)));
  endfunction

endpackage

// File: rtl/clk_en_stage.sv
// -----------------------------------------------------------------------------
// clk_en_stage
// One divider stage: a counter advanced by a source enable, plus registered
// level and tick outputs. Everything runs on clk_g; there are no derived clocks.
// Ports:
//   clk_g     in   system clock
//   rst_n     in   asynchronous active-low reset
//   src_en    in   advance the counter this cycle
//   hold      in   force counter to 0 and outputs low
//   ratio     in   programmed divide ratio (0/1 behave as 2)
//   wrap_comb out  combinational wrap condition, used as the enable of
//                  stages sourced from this one
//   clk_out   out  divided clock level (registered)
//   tick      out  one-cycle strobe per output period (registered)
// -----------------------------------------------------------------------------
module clk_en_stage
  import clkgen_pkg::*;
#(
  parameter int CNT_W = CNT_W_DEF
) (
  input  logic             clk_g,
  input  logic             rst_n,
  input  logic             src_en,
  input  logic             hold,
  input  logic [CNT_W-1:0] ratio,
  output logic             wrap_comb,
  output logic             clk_out,
  output logic             tick
);

  logic [CNT_W-1:0] div_eff;
  logic [CNT_W-1:0] half_div;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic             clk_q, clk_d;
  logic             tick_q, tick_d;
  logic             wrap_w;

  // The level is derived from the next counter value so that the falling edge
  // lands in the same cycle as the tick, and odd ratios spend the extra source
  // period high.
  always_comb begin
    div_eff  = CNT_W'(eff_div(32'(ratio)));
    half_div = div_eff >> 1;
    wrap_w   = src_en & ~hold & (cnt_q == (div_eff - CNT_W'(1)));
    cnt_d    = cnt_q;
    if (hold) begin
      cnt_d = '0;
    end else if (src_en) begin
      cnt_d = wrap_w ? '0 : (cnt_q + CNT_W'(1));
    end
    tick_d = wrap_w;
    clk_d  = ~hold & (cnt_d >= half_div);
  end

  always_ff @(posedge clk_g or negedge rst_n) begin
    if (!rst_n) begin
      cnt_q  <= '0;
      clk_q  <= 1'b0;
      tick_q <= 1'b0;
    end else begin
      cnt_q  <= cnt_d;
      clk_q  <= clk_d;
      tick_q <= tick_d;
    end
  end

  assign wrap_comb = wrap_w;
  assign clk_out   = clk_q;
  assign tick      = tick_q;

endmodule

// File: rtl/clk_en_bank.sv
// -----------------------------------------------------------------------------
// clk_en_bank
// Bank of NUM_OUT clock-enable dividers arranged as a tree. Each stage counts
// either every CLK_G cycle (selector 4'hF) or on the wrap of a lower-numbered
// stage, giving zero-skew divided levels and tick strobes for the SPI, ADC,
// CIC and Hadamard front-end timing.
// Optional build macro CLKGEN_FRAME_CNT_EN adds FRAME_CNT, a 32-bit count of
// TICK[NUM_OUT-1] events used for timestamping.
// Ports:
//   CLK_G     in   system clock (6.144 MHz)
//   RST_N     in   asynchronous active-low reset
//   SPI_EN    in   synchronous hold; falling restarts all stages aligned
//   CFG_LOAD  in   single-cycle ratio write strobe (accepted only in hold)
//   CFG_DIV   in   new ratios, stage k at [CNT_W*k +: CNT_W]
//   CFG_ERR   out  sticky flag: CFG_LOAD seen while not in hold
//   CLK_OUT   out  divided clock levels
//   TICK      out  one-cycle strobe per output period
//   RUN       out  dividers are counting
//   FRAME_CNT out  (CLKGEN_FRAME_CNT_EN only) count of final-stage ticks
// -----------------------------------------------------------------------------
module clk_en_bank
  import clkgen_pkg::*;
#(
  parameter int                       NUM_OUT = 4,
  parameter int                       CNT_W   = CNT_W_DEF,
  parameter logic [4*NUM_OUT-1:0]     SRC_SEL = {4'd2, 4'd1, 4'hF, 4'hF},
  parameter logic [NUM_OUT*CNT_W-1:0] DIV_DEF = {8'd8, 8'd8, 8'd12, 8'd8}
) (
  input  logic                     CLK_G,
  input  logic                     RST_N,
  input  logic                     SPI_EN,
  input  logic                     CFG_LOAD,
  input  logic [NUM_OUT*CNT_W-1:0] CFG_DIV,
  output logic                     CFG_ERR,
  output logic [NUM_OUT-1:0]       CLK_OUT,
  output logic [NUM_OUT-1:0]       TICK,
  output logic                     RUN
`ifdef CLKGEN_FRAME_CNT_EN
  ,
  output logic [31:0]              FRAME_CNT
`endif
);

  if ((NUM_OUT < 1) || (NUM_OUT > 15)) begin : g_bad_num_out
    $error("clk_en_bank: NUM_OUT must be in 1..15");
  end

  if (CNT_W < 2) begin : g_bad_cnt_w
    $error("clk_en_bank: CNT_W must be at least 2");
  end

  logic                     run_q, run_d;
  logic                     cfg_err_q, cfg_err_d;
  logic [NUM_OUT*CNT_W-1:0] ratio_q, ratio_d;
  logic                     hold_w;

  // Stages are held while SPI_EN is high and also for the first cycle after
  // it samples low, so counting starts together with RUN and the first tick
  // arrives a full period after RUN rises. Holding on SPI_EN directly also
  // truncates all outputs low one cycle after SPI_EN is sampled high.
  always_comb begin
    run_d     = ~SPI_EN;
    hold_w    = SPI_EN | ~run_q;
    ratio_d   = ratio_q;
    cfg_err_d = cfg_err_q;
    if (CFG_LOAD) begin
      if (SPI_EN) begin
        ratio_d = CFG_DIV;
      end else begin
        cfg_err_d = 1'b1;
      end
    end
  end

  always_ff @(posedge CLK_G or negedge RST_N) begin
    if (!RST_N) begin
      run_q     <= 1'b0;
      cfg_err_q <= 1'b0;
      ratio_q   <= DIV_DEF;
    end else begin
      run_q     <= run_d;
      cfg_err_q <= cfg_err_d;
      ratio_q   <= ratio_d;
    end
  end

  assign RUN     = run_q;
  assign CFG_ERR = cfg_err_q;

  for (genvar k = 0; k < NUM_OUT; k++) begin : g_stage
    localparam logic [3:0] SEL =
      4'(get_field(MAX_VEC_W'(SRC_SEL), k, 4));

    logic src_en_w;
    logic wrap_w;

    // A child stage advances on its parent's combinational wrap, in the same
    // cycle the parent wraps, which keeps every level in the tree edge-aligned.
    if (SEL == SRC_ROOT) begin : g_root
      assign src_en_w = 1'b1;
    end else if (int'(SEL) < k) begin : g_tree
      assign src_en_w = g_stage[SEL].wrap_w;
    end else begin : g_bad_src
      $error("clk_en_bank: SRC_SEL field must be 4'hF or a lower stage index");
      assign src_en_w = 1'b0;
    end

    clk_en_stage #(
      .CNT_W (CNT_W)
    ) u_stage (
      .clk_g     (CLK_G),
      .rst_n     (RST_N),
      .src_en    (src_en_w),
      .hold      (hold_w),
      .ratio     (ratio_q[CNT_W*k +: CNT_W]),
      .wrap_comb (wrap_w),
      .clk_out   (CLK_OUT[k]),
      .tick      (TICK[k])
    );
  end

`ifdef CLKGEN_FRAME_CNT_EN
  logic [31:0] frame_q, frame_d;

  // Counts on the final stage's wrap so the count steps in the same cycle
  // its TICK is presented; natural 32-bit rollover.
  always_comb begin
    frame_d = frame_q;
    if (hold_w) begin
      frame_d = '0;
    end else if (g_stage[NUM_OUT-1].wrap_w) begin
      frame_d = frame_q + 32'd1;
    end
  end

  always_ff @(posedge CLK_G or negedge RST_N) begin
    if (!RST_N) begin
      frame_q <= '0;
    end else begin
      frame_q <= frame_d;
    end
  end

  assign FRAME_CNT = frame_q;
`else
  // Frame counter not built; the divider bank is otherwise identical.
`endif

endmodule

// File: tb/tb_clk_en_bank.sv
// -----------------------------------------------------------------------------
// tb_clk_en_bank
// Self-checking bench for clk_en_bank with default parameters. A period-based
// model predicts TICK/CLK_OUT/RUN/CFG_ERR each cycle; directed scenarios add
// hand-computed timing expectations.
// -----------------------------------------------------------------------------
module tb_clk_en_bank;

  localparam int NUM_OUT = 4;
  localparam int CNT_W   = 8;

  logic                     CLK_G;
  logic                     RST_N;
  logic                     SPI_EN;
  logic                     CFG_LOAD;
  logic [NUM_OUT*CNT_W-1:0] CFG_DIV;
  logic                     CFG_ERR;
  logic [NUM_OUT-1:0]       CLK_OUT;
  logic [NUM_OUT-1:0]       TICK;
  logic                     RUN;
`ifdef CLKGEN_FRAME_CNT_EN
  logic [31:0]              FRAME_CNT;
`endif

  clk_en_bank dut (
    .CLK_G    (CLK_G),
    .RST_N    (RST_N),
    .SPI_EN   (SPI_EN),
    .CFG_LOAD (CFG_LOAD),
    .CFG_DIV  (CFG_DIV),
    .CFG_ERR  (CFG_ERR),
    .CLK_OUT  (CLK_OUT),
    .TICK     (TICK),
    .RUN      (RUN)
`ifdef CLKGEN_FRAME_CNT_EN
    ,
    .FRAME_CNT(FRAME_CNT)
`endif
  );

  initial CLK_G = 1'b0;
  always #5 CLK_G = ~CLK_G;

  int checks   = 0;
  int failures = 0;
  int cyc      = 0;

  always @(posedge CLK_G) cyc <= cyc + 1;

  // Source of each stage (15 = every CLK_G cycle) and reset ratios.
  int src_of  [NUM_OUT] = '{15, 15, 1, 2};
  int def_div [NUM_OUT] = '{8, 12, 8, 8};

  // Model: n counts running cycles since restart. A stage with source period
  // Ps and ratio d has output period P = d*Ps; it ticks when n is a multiple of
  // P and is high for the upper ceil(d/2) of the d source periods.
  int                 m_ratio [NUM_OUT];
  int                 m_per   [NUM_OUT];
  int                 m_src_per;
  int                 m_d;
  int                 m_n;
  logic               m_run;
  logic               m_err;
  logic [NUM_OUT-1:0] m_tick;
  logic [NUM_OUT-1:0] m_clk;

  function automatic int eff(input int r);
    return (r < 2) ? 2 : r;
  endfunction

  always @(posedge CLK_G or negedge RST_N) begin
    if (!RST_N) begin
      m_n    = 0;
      m_run  = 1'b0;
      m_err  = 1'b0;
      m_tick = '0;
      m_clk  = '0;
      for (int k = 0; k < NUM_OUT; k++) m_ratio[k] = def_div[k];
    end else begin
      if (SPI_EN || !m_run) begin
        m_n    = 0;
        m_tick = '0;
        m_clk  = '0;
      end else begin
        m_n = m_n + 1;
        for (int k = 0; k < NUM_OUT; k++) begin
          m_d       = eff(m_ratio[k]);
          m_src_per = (src_of[k] == 15) ? 1 : m_per[src_of[k]];
          m_per[k]  = m_d * m_src_per;
          m_tick[k] = ((m_n % m_per[k]) == 0);
          m_clk[k]  = (((m_n / m_src_per) % m_d) >= (m_d / 2));
        end
      end
      if (CFG_LOAD) begin
        if (SPI_EN) begin
          for (int k = 0; k < NUM_OUT; k++) m_ratio[k] = int'(CFG_DIV[k*CNT_W +: CNT_W]);
        end else begin
          m_err = 1'b1;
        end
      end
      m_run = !SPI_EN;
    end
  end

  task automatic checkOutput(input string name, input logic [31:0] got, input logic [31:0] want);
    checks = checks + 1;
    if (got !== want) begin
      failures = failures + 1;
      $display("[TB] FAIL %s: got %0h expected %0h at time %0t", name, got, want, $time);
    end
  endtask

  // Per-cycle comparison against the model, away from the active edge.
  always @(negedge CLK_G) begin
    if (RST_N === 1'b1) begin
      checkOutput("model_tick", 32'(TICK), 32'(m_tick));
      checkOutput("model_clk_out", 32'(CLK_OUT), 32'(m_clk));
      checkOutput("model_run", 32'(RUN), 32'(m_run));
      checkOutput("model_cfg_err", 32'(CFG_ERR), 32'(m_err));
    end
  end

  task automatic applyStimulus(input logic spi, input logic load, input logic [31:0] div);
    @(posedge CLK_G);
    #1;
    SPI_EN   = spi;
    CFG_LOAD = load;
    CFG_DIV  = div;
  endtask

  // which = 0..NUM_OUT-1 waits for TICK[which]; which = NUM_OUT waits for RUN.
  // Returns the cycle stamp, or -1 if the budget runs out.
  task automatic waitSig(input int which, input int budget, output int at);
    at = -1;
    for (int i = 0; i < budget; i++) begin
      @(negedge CLK_G);
      if ((which == NUM_OUT) ? (RUN === 1'b1) : (TICK[which] === 1'b1)) begin
        at = cyc;
        break;
      end
    end
  endtask

  int         t0, t, ta, tb;
  logic [7:0] pat;

  initial begin
    RST_N    = 1'b0;
    SPI_EN   = 1'b1;
    CFG_LOAD = 1'b0;
    CFG_DIV  = '0;
    #23;
    checkOutput("reset_tick", 32'(TICK), 32'd0);
    checkOutput("reset_clk_out", 32'(CLK_OUT), 32'd0);
    checkOutput("reset_run", 32'(RUN), 32'd0);
    checkOutput("reset_cfg_err", 32'(CFG_ERR), 32'd0);
    @(posedge CLK_G);
    #1;
    RST_N = 1'b1;
    applyStimulus(1'b1, 1'b0, 32'h0);
    applyStimulus(1'b1, 1'b0, 32'h0);

    // Default ratios: 8 / 12 / 96 / 768 cycle periods.
    applyStimulus(1'b0, 1'b0, 32'h0);
    waitSig(NUM_OUT, 20, t0);
    waitSig(0, 50, t);
    checkOutput("def_first_tick0", 32'(t - t0), 32'd8);
    waitSig(3, 2000, t);
    checkOutput("def_first_tick3", 32'(t - t0), 32'd768);
    waitSig(2, 200, ta);
    checkOutput("def_tick2_period", 32'(ta - t), 32'd96);
    for (int i = 0; i < 8; i++) begin
      pat[i] = CLK_OUT[0];
      @(negedge CLK_G);
    end
    checkOutput("def_clk0_pattern", 32'(pat), 32'h0000_00F0);
    waitSig(1, 50, ta);
    waitSig(1, 50, tb);
    checkOutput("def_tick1_period", 32'(tb - ta), 32'd12);

    // Odd ratio 5 on stage 0; the stage 1->2->3 chain is untouched.
    applyStimulus(1'b1, 1'b1, 32'h0808_0C05);
    applyStimulus(1'b1, 1'b0, 32'h0808_0C05);
    applyStimulus(1'b1, 1'b0, 32'h0808_0C05);
    applyStimulus(1'b0, 1'b0, 32'h0808_0C05);
    waitSig(NUM_OUT, 20, t0);
    waitSig(0, 50, t);
    checkOutput("odd_first_tick0", 32'(t - t0), 32'd5);
    pat = '0;
    for (int i = 0; i < 5; i++) begin
      pat[i] = CLK_OUT[0];
      @(negedge CLK_G);
    end
    checkOutput("odd_clk0_pattern", 32'(pat), 32'h0000_001C);
    waitSig(3, 2000, t);
    checkOutput("odd_first_tick3", 32'(t - t0), 32'd768);

    // Clamp: stage1 ratio 0 and stage2 ratio 1 both divide by 2.
    applyStimulus(1'b1, 1'b1, 32'h0801_0008);
    applyStimulus(1'b1, 1'b0, 32'h0801_0008);
    applyStimulus(1'b0, 1'b0, 32'h0801_0008);
    waitSig(NUM_OUT, 20, t0);
    waitSig(1, 20, t);
    checkOutput("clamp_first_tick1", 32'(t - t0), 32'd2);
    waitSig(2, 20, t);
    checkOutput("clamp_first_tick2", 32'(t - t0), 32'd4);
    waitSig(1, 20, ta);
    waitSig(1, 20, tb);
    checkOutput("clamp_tick1_period", 32'(tb - ta), 32'd2);

    // Load while running is rejected and flagged.
    applyStimulus(1'b0, 1'b1, 32'h0801_0003);
    applyStimulus(1'b0, 1'b0, 32'h0801_0003);
    @(negedge CLK_G);
    checkOutput("run_load_cfg_err", 32'(CFG_ERR), 32'd1);
    waitSig(0, 50, ta);
    waitSig(0, 50, tb);
    checkOutput("run_load_tick0_period", 32'(tb - ta), 32'd8);

    // Hold pulse mid-period, then a phase-aligned restart.
    applyStimulus(1'b1, 1'b1, 32'h0808_0C08);
    applyStimulus(1'b1, 1'b0, 32'h0808_0C08);
    applyStimulus(1'b0, 1'b0, 32'h0808_0C08);
    waitSig(NUM_OUT, 20, t0);
    for (int i = 0; i < 100 && cyc < t0 + 36; i++) @(negedge CLK_G);
    applyStimulus(1'b1, 1'b0, 32'h0808_0C08);
    @(posedge CLK_G);
    @(negedge CLK_G);
    checkOutput("hold_tick", 32'(TICK), 32'd0);
    checkOutput("hold_clk_out", 32'(CLK_OUT), 32'd0);
    checkOutput("hold_run", 32'(RUN), 32'd0);
    applyStimulus(1'b0, 1'b0, 32'h0808_0C08);
    waitSig(NUM_OUT, 20, t0);
    waitSig(3, 2000, t);
    checkOutput("restart_first_tick3", 32'(t - t0), 32'd768);

    // Asynchronous reset mid-cycle while running with a non-default ratio.
    applyStimulus(1'b1, 1'b1, 32'h0808_0C05);
    applyStimulus(1'b1, 1'b0, 32'h0808_0C05);
    applyStimulus(1'b0, 1'b0, 32'h0808_0C05);
    waitSig(NUM_OUT, 20, t0);
    waitSig(1, 50, t);
    @(posedge CLK_G);
    #3;
    RST_N = 1'b0;
    #1;
    checkOutput("areset_tick", 32'(TICK), 32'd0);
    checkOutput("areset_clk_out", 32'(CLK_OUT), 32'd0);
    checkOutput("areset_run", 32'(RUN), 32'd0);
    checkOutput("areset_cfg_err", 32'(CFG_ERR), 32'd0);
    @(posedge CLK_G);
    #1;
    RST_N = 1'b1;
    waitSig(NUM_OUT, 20, t0);
    waitSig(0, 50, t);
    checkOutput("areset_ratio_default", 32'(t - t0), 32'd8);

    repeat (3) @(negedge CLK_G);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

  initial begin
    #2000000;
    failures = failures + 1;
    $display("[TB] FAIL watchdog: simulation exceeded time limit");
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $fatal(1, "[TB] watchdog expired");
  end

endmodule

// File: doc/clk_en_bank.md
Name: clk_en_bank

Overview:
Parametrised successor to the fixed ripple clock divider. It generates NUM_OUT divided clock levels and matching single-cycle tick strobes. Every flop runs on CLK_G alone, with no ripple clocks and no resynchronisation stage. Per-stage divide ratios are runtime-programmable, and a per-stage source selection (parameter) forms a divider tree. The block sits under Global_Control_Top and feeds the SPI, ADC, CIC and Hadamard front-end timing.

Parameters:
NUM_OUT, 4, number of divider stages, 1..15.
CNT_W, 8, width of each stage counter and ratio field.
SRC_SEL, {4'd2,4'd1,4'hF,4'hF}, per-stage source, 4 bits per stage, stage k at [4k+:4]. 4'hF = CLK_G (every cycle); otherwise the source is a stage index less than k. Any other value is an elaboration error.
DIV_DEF, {8'd8,8'd8,8'd12,8'd8}, reset ratio per stage, stage k at [CNT_W*k+:CNT_W]. At 6.144 MHz this gives 768k/512k/64k/8k.

Ports:
CLK_G  in  1  system clock, 6.144 MHz.
RST_N  in  1  asynchronous active-low reset.
SPI_EN  in  1  synchronous hold/restart while high.
CFG_LOAD  in  1  single-cycle ratio write strobe.
CFG_DIV  in  NUM_OUT*CNT_W  new ratios, same packing as DIV_DEF.
CFG_ERR  out  1  sticky: CFG_LOAD arrived while running.
CLK_OUT  out  NUM_OUT  divided clock levels.
TICK  out  NUM_OUT  one CLK_G-cycle strobe per output period.
RUN  out  1  high when dividers are counting.

Behaviour:
- Interface: one clock, CLK_G. Reset is asynchronous and active-low (RST_N).
- Reset (RST_N=0):
  - all counters = 0; CLK_OUT = 0, TICK = 0, RUN = 0, CFG_ERR = 0.
  - active ratios = DIV_DEF.
- Hold (SPI_EN=1):
  - counters held at 0; CLK_OUT = 0, TICK = 0, RUN = 0.
  - SPI_EN falling restarts every stage phase-aligned; RUN = 1 on the first cycle after SPI_EN samples low.
- Source enable: src_en[k] = 1 every cycle for source F, else TICK-internal of the source stage, i.e. the combinational wrap condition of that stage in the same cycle. This keeps the tree zero-skew.
- Stage counting:
  - effective ratio d = max(ratio, 2).
  - on src_en: cnt <= (cnt == d-1) ? 0 : cnt+1.
  - wrap condition w = src_en & (cnt == d-1).
- Outputs (all registered, 1 CLK_G latency after the counter update):
  - TICK[k] <= w.
  - CLK_OUT[k] <= (cnt_next >= d>>1).
  - Low for floor(d/2) source periods, high for ceil(d/2). Odd d gives the extra source period high.
  - The CLK_OUT falling edge coincides with TICK.
  - After restart each output starts low.
- Ratio write:
  - CFG_LOAD while SPI_EN=1 copies CFG_DIV to the active ratios next cycle; takes effect at release.
  - CFG_LOAD while SPI_EN=0 is ignored and sets CFG_ERR. CFG_ERR clears only on RST_N.
  - CFG_LOAD coincident with SPI_EN rising is accepted, since SPI_EN is sampled in the same cycle.
- Ratio 0 or 1 is clamped to 2. There is no out-of-range failure; the counter width is the bound (max 2^CNT_W-1).
- Reset mid-operation: asynchronous clear to the reset state. A hold mid-period truncates all outputs low within 1 cycle; no glitches, since all outputs come straight from flops.

Optional Feature:
CLKGEN_FRAME_CNT_EN.
- Defined: adds output FRAME_CNT [31:0]. It increments on TICK[NUM_OUT-1], wraps at 2^32-1 -> 0, and clears on reset and while SPI_EN=1. Used for timestamping downsampled data.
- Undefined: the port and counter are absent; behaviour is otherwise identical.

Decomposition:
- Package clkgen_pkg:
  - SRC_ROOT = 4'hF.
  - CNT_W default.
  - function eff_div (clamp to >=2).
  - function field extraction for packed vectors.
- Sub-module clk_en_stage (one counter plus output flops):
  - inputs: src_en, ratio, hold.
  - outputs: wrap_comb, CLK_OUT, TICK.
- Top instantiates NUM_OUT stages in a generate loop. It also holds the source mux, config register, CFG_ERR and the optional frame counter.

Test Plan:
- Defaults, SPI_EN released: TICK[0] every 8 cycles, TICK[1] every 12, TICK[2] every 96, TICK[3] every 768. The first TICK[0] appears 8 cycles after RUN rises. CLK_OUT[0] pattern is 4 low / 4 high.
- Odd ratio: hold, load stage0 = 5, release -> CLK_OUT[0] 2 low / 3 high, TICK[0] period 5. Stage3 (sourced via stage 2 from stage 1) is unchanged at period 768.
- Clamp: load stage1 = 0 and stage2 = 1 -> both behave as d = 2. TICK[1] every 2 cycles; TICK[2] every 4.
- CFG_LOAD during run with stage0 = 3 -> ratios unchanged (period stays 8) and CFG_ERR = 1 until RST_N.
- SPI_EN pulse mid-period at cycle 37 -> all outputs 0 the next cycle. After release, the TICK[3] phase restarts with its first TICK at 768 cycles.
- RST_N asserted asynchronously mid-cycle -> outputs 0 immediately; active ratios revert to DIV_DEF. With CLKGEN_FRAME_CNT_EN defined, FRAME_CNT = 0 and reads 3 after 2304 cycles of run.
